// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider. Each channel produces a divided square wave
// and a registered rising-edge tick; new divisors are applied only at period boundaries.
module clock_divider_multi #(
    parameter int CHANNELS  = 2,
    parameter int WIDTH     = 25,
    parameter int DEFAULT_N = 4
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic [CHANNELS-1:0] en,
    input  logic [CHANNELS-1:0] load,
    input  logic [WIDTH-1:0]    n_in,
    input  logic                sync,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);

    logic [WIDTH-1:0]    counter_q [CHANNELS];
    logic [WIDTH-1:0]    counter_d [CHANNELS];
    logic [WIDTH-1:0]    active_q  [CHANNELS];
    logic [WIDTH-1:0]    active_d  [CHANNELS];
    logic [WIDTH-1:0]    shadow_q  [CHANNELS];
    logic [WIDTH-1:0]    shadow_d  [CHANNELS];
    logic [CHANNELS-1:0] clk_q, clk_d;
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [CHANNELS-1:0] pending_q, pending_d;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            counter_d[i] = counter_q[i];
            active_d[i]  = active_q[i];
            shadow_d[i]  = shadow_q[i];
        end
        clk_d     = clk_q;
        tick_d    = '0;
        pending_d = pending_q;

        for (int i = 0; i < CHANNELS; i++) begin
            if (sync) begin
                counter_d[i] = '0;
                clk_d[i]     = 1'b0;
                if (pending_q[i] && !load[i]) begin
                    active_d[i]  = shadow_q[i];
                    pending_d[i] = 1'b0;
                end
            end else if (en[i] && (active_q[i] != '0)) begin
                // The >= compare also pulls an out-of-range counter back into its period.
                if (counter_q[i] >= active_q[i] - WIDTH'(1)) begin
                    counter_d[i] = '0;
                    clk_d[i]     = ~clk_q[i];
                    tick_d[i]    = ~clk_q[i];
                    if (pending_q[i]) begin
                        active_d[i]  = shadow_q[i];
                        pending_d[i] = 1'b0;
                    end
                end else begin
                    counter_d[i] = counter_q[i] + WIDTH'(1);
                end
            end else if (!en[i]) begin
                if (pending_q[i] && !load[i]) begin
                    active_d[i]  = shadow_q[i];
                    pending_d[i] = 1'b0;
                end
            end else begin
                counter_d[i] = '0;
                clk_d[i]     = 1'b0;
                if (pending_q[i] && !load[i]) begin
                    active_d[i]  = shadow_q[i];
                    pending_d[i] = 1'b0;
                end
            end

            // A load in the same cycle as a transfer lands in the shadow for the next boundary.
            if (load[i]) begin
                shadow_d[i]  = n_in;
                pending_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                counter_q[i] <= '0;
                active_q[i]  <= WIDTH'(DEFAULT_N);
                shadow_q[i]  <= WIDTH'(DEFAULT_N);
            end
            clk_q     <= '0;
            tick_q    <= '0;
            pending_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                counter_q[i] <= counter_d[i];
                active_q[i]  <= active_d[i];
                shadow_q[i]  <= shadow_d[i];
            end
            clk_q     <= clk_d;
            tick_q    <= tick_d;
            pending_q <= pending_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign pending = pending_q;

endmodule

// File: doc/clock_divider_multi.md
Name: clock_divider_multi

Overview:
- Multi-channel programmable clock divider. Each channel produces a divided square wave and a one-cycle tick, both derived from one fast clock.
- Per-channel divisors are loaded at runtime through a shadow register. A new divisor takes effect only at a period boundary, so the output never glitches.
- Sits between the system clock and rate-dependent consumers: audio sample-rate strobes, LED/scan timers and speed control.

Parameters:
- CHANNELS, 2, number of independent divider channels.
- WIDTH, 25, width of divisor and counter per channel.
- DEFAULT_N, 4, half-period divisor loaded into every channel at reset (must be < 2^WIDTH).

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  CHANNELS  per-channel run enable.
- load  input  CHANNELS  per-channel strobe; captures n_in into that channel's shadow divisor.
- n_in  input  WIDTH  shared divisor bus; half-period in clk_in cycles.
- sync  input  1  synchronous phase-align pulse for all channels.
- clk_out  output  CHANNELS  divided clocks; period = 2*n cycles.
- tick  output  CHANNELS  one-cycle pulse, registered; high in the cycle clk_out goes 0->1.
- pending  output  CHANNELS  high while the shadow divisor is not yet applied.

Behaviour:
- Reset (reset=0, async):
  - counter=0, clk_out=0, tick=0, pending=0.
  - active_n=shadow_n=DEFAULT_N.
  - Takes effect immediately, including mid-period. Released synchronously on the next clk_in edge.
- Per-channel state: counter[WIDTH], active_n, shadow_n, pending, clk_out, tick.
- Channel "running" means en[i]=1 and active_n!=0. Otherwise the channel is "idle".
- Running:
  - Each cycle, if counter >= active_n-1: counter<=0 and clk_out toggles (a "wrap"). Else counter<=counter+1.
  - tick<=1 only on a wrap where clk_out goes 0->1; tick=0 in all other cycles.
  - First rising edge occurs active_n cycles after en rises from a reset state.
- Idle, en=0: counter and clk_out hold their values; tick=0.
- Idle, active_n=0: counter<=0, clk_out<=0, tick=0.
- Divisor load:
  - load[i]=1 sets shadow_n<=n_in and pending<=1.
  - Running: on the next wrap, active_n<=shadow_n and pending<=0.
  - Idle: transfer happens on the next cycle in which load[i]=0.
- load coinciding with a wrap: the wrap transfers the old shadow_n. The new value is captured into shadow_n with pending=1 and applies at the following wrap.
- Multiple loads before a wrap: the last load wins.
- sync=1 (priority over count, below reset), applied to all channels:
  - counter<=0, clk_out<=0, tick<=0.
  - If pending and load[i]=0: active_n<=shadow_n, pending<=0.
  - load in the same cycle as sync captures into shadow only; applied at the next wrap.
  - Channels with equal active_n stay phase-aligned afterwards.
- n=1: clk_out toggles every cycle (period 2); tick every 2 cycles.
- n=2^WIDTH-1: no overflow. The counter never exceeds active_n-1. The >= compare recovers from any out-of-range counter value.
- Channels are fully independent except for the shared n_in bus and sync.

Test Plan:
Bench uses CHANNELS=2, WIDTH=8, DEFAULT_N=4.
1. Reset release, en=2'b11, no loads -> both clk_out period 8 cycles; first 0->1 on the 4th edge after en; tick high exactly 1 cycle every 8; pending=0.
2. Ch0 running at n=4, counter=1: load[0]=1 with n_in=2 -> pending[0]=1 until the next wrap 2 cycles later, then pending[0]=0; subsequent period is 4; ch1 unaffected (period 8).
3. load n_in=1 on ch1 -> after boundary, clk_out[1] toggles every cycle and tick[1] pulses every 2 cycles.
4. load n_in=0 on ch0 -> at the wrap, active becomes 0; clk_out[0]=0 held, tick[0]=0. Then load n_in=3 -> applied the next cycle (idle path); first rising edge 3 cycles later; period 6.
5. Ch0 n=4, ch1 n=4 out of phase (ch1 enabled 2 cycles late), pulse sync -> both clk_out=0 and counters=0 in the same cycle; afterwards edges coincide.
6. Assert reset mid-period with pending=1 -> clk_out, tick, pending go 0 without a clock edge; after release, period is 8 (DEFAULT_N restored).
7. en[0] dropped for 5 cycles mid-period -> clk_out[0] and counter frozen; resumes the remaining half-period count on re-enable.
